irq_pending_latch: RTL and testbench
====================================

# irq_pending_latch

Interrupt-request front end that sits directly upstream of the 8-to-3 priority encoder. It synchronises eight asynchronous request lines and detects their rising edges. Requests are held in a sticky pending register, and the masked pending vector is driven to the encoder's `din`. The encoder's `dout`/`valid` are taken back, and each winning index is issued to the consumer through a req/ack handshake; the pending bit is cleared on acknowledge.

## Interface
- `SYNC_STAGES`, 2, flip-flop depth of the input synchroniser (≥2).
- `clk`  input  1  single system clock, all flops rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `irq_in`  input  8  asynchronous request lines; a 0→1 transition raises a request.
- `mask_we`  input  1  write strobe for the mask register.
- `mask_wdata`  input  8  new mask value; bit=1 masks that source.
- `mask`  output  8  current mask register.
- `pending`  output  8  raw sticky pending register, unmasked.
- `pend_vec`  output  8  `pending & ~mask`, combinational; connects to encoder `din`.
- `enc_dout`  input  3  index from the encoder.
- `enc_valid`  input  1  encoder valid.
- `irq_req`  output  1  registered request to the consumer.
- `irq_id`  output  3  registered index of the issued request; stable while `irq_req`=1.
- `irq_ack`  input  1  consumer acknowledge, sampled only while `irq_req`=1.

## Operation
- **Synchroniser:** each `irq_in` bit passes through `SYNC_STAGES` flops, then one extra delay flop. Edge = synced & ~delayed.
- **Pending register:**
  - A bit is set on its edge.
  - A bit is cleared when the ack handshake completes for `irq_id` == that bit.
  - Same bit set and cleared in one cycle: set wins and the bit stays 1.
  - Pending is never cleared by masking; masked bits remain pending and reappear when unmasked.
- **Mask:** loaded from `mask_wdata` on `mask_we`; takes effect on `pend_vec` the cycle after the write.
- **FSM** (3 states):
  - IDLE: `irq_req`=0. If `enc_valid`=1, latch `enc_dout` into `irq_id` and go to ISSUE. `irq_req`=1 from the next edge.
  - ISSUE: `irq_req`=1 and `irq_id` held. On `irq_ack`=1, clear `pending[irq_id]`, deassert `irq_req`, and go to GAP.
    - A request is never withdrawn once issued, even if its source becomes masked or a higher-priority bit arrives.
  - GAP: one cycle with `irq_req`=0 so the encoder sees the updated vector. Unconditionally returns to IDLE.
- **Ignored acknowledges:** `irq_ack` outside ISSUE is ignored and must not alter `pending`.
- **Reset values:** all outputs and state are 0.
  - `irq_req`=0, `irq_id`=0, `pending`=0, `pend_vec`=0.
  - `mask`=8'h00, so all sources are enabled.
  - Synchroniser and delay flops are 0, so a line already high at reset release produces one edge.
  - FSM returns to IDLE.
- **Reset mid-operation:** an `rst_n` assertion in any state immediately forces `irq_req`=0 and clears `pending`, with no clock required. Requests in flight are lost.

## Timing
- **Request latency** (`SYNC_STAGES`=2), counting from the first clock edge at which `irq_in` is sampled high:
  - Edge 1: sync1.
  - Edge 2: sync2 (edge detected).
  - Edge 3: `pending`/`pend_vec` set.
  - Edge 4: `irq_req`=1 with `irq_id` valid.
- **Ack handshake:** `irq_ack` sampled high at edge A gives `irq_req`=0 and `pending[id]`=0 after A, GAP during A→A+1, and IDLE evaluation at A+1. The next request can assert at A+2 at the earliest, so the minimum back-to-back spacing is 3 cycles of `irq_req` low→high.
- **Mask write:** a mask write at edge W is visible on `pend_vec` after W. A request latched at W uses the pre-write value.
- **Held lines:** a line held high produces exactly one pending event. A second event needs the line to drop low for at least one sampled cycle and then rise again.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ISSUE → `irq_req`, `pending`, `pend_vec` and `irq_id` are 0 immediately; `mask`=00.
- **Single request:** `irq_in`=8'h04 rising → `pending`=04 at edge 3, `irq_req`=1 with `irq_id`=3'd2 at edge 4. Ack → `pending`=00, `irq_req`=0, no re-issue while the line stays high.
- **Priority service:** edges on bits 7 and 5 together → issue id 7, ack; then issue id 5 at ack+2, ack; `pending`=00.
- **Mask:** `mask`=8'h80 and edges on 7 and 1 → issue id 1. Ack, then unmask → issue id 7 (it stayed pending).
- **Set/clear collision:** during ISSUE id 3, pulse `irq_in[3]` so its edge lands in the same cycle as `irq_ack` → `pending[3]` remains 1 and id 3 re-issues.
- **Stray ack:** `irq_ack`=1 in IDLE with `pending`=8'h10 → `pending` is unchanged and id 4 is still issued.

Source files
------------

// File: rtl/irq_pending_latch_if.sv
// Consumer-side request/acknowledge channel of the interrupt front end.
// The latch drives the request and the winning index; the consumer returns the acknowledge.
interface irq_pending_latch_if;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       irq_ack;

  modport master (
    output irq_req,
    output irq_id,
    input  irq_ack
  );

  modport slave (
    input  irq_req,
    input  irq_id,
    output irq_ack
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Interrupt front end: synchronises eight request lines, latches their rising edges as sticky
// pending bits, feeds the masked vector to an external priority encoder and issues its winners.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           irq_in,
  input  logic                 mask_we,
  input  logic [7:0]           mask_wdata,
  output logic [7:0]           mask,
  output logic [7:0]           pending,
  output logic [7:0]           pend_vec,
  input  logic [2:0]           enc_dout,
  input  logic                 enc_valid,
  irq_pending_latch_if.master  irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][7:0] sync_p0;
  logic [7:0]                  dly_p1;
  logic [7:0]                  rise_p1;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] irq_id_q;
  logic [2:0] irq_id_d;
  logic       irq_req_q;
  logic [7:0] clr_vec;
  logic [7:0] pending_d;

  // Stage p0: synchroniser chain; the extra delay flop provides the previous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      dly_p1  <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], irq_in};
      dly_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  // Stage p1: rising-edge detect feeds the sticky pending register
  assign rise_p1 = sync_p0[SYNC_STAGES-1] & ~dly_p1;

  // A new edge wins over a same-cycle acknowledge clear of that bit
  assign pending_d = (pending & ~clr_vec) | rise_p1;
  assign pend_vec  = pending & ~mask;

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr_vec  = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d  = ISSUE;
          irq_id_d = enc_dout;
        end
      end
      ISSUE: begin
        if (irq.irq_ack) begin
          state_d = GAP;
          clr_vec = 8'h01 << irq_id_q;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_id_q  <= 3'd0;
      irq_req_q <= 1'b0;
      pending   <= 8'h00;
      mask      <= 8'h00;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      irq_req_q <= (state_d == ISSUE);
      pending   <= pending_d;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

  assign irq.irq_req = irq_req_q;
  assign irq.irq_id  = irq_id_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Randomised and directed bench for irq_pending_latch with a behavioural model, an issue
// scoreboard and a queue of timed expectations, all compared in one monitor process.
module tb_irq_pending_latch;
  localparam int SYNC = 2;

  typedef struct {
    int         cyc;
    int         kind;   // 0: value check, 1: expired wait, 2: scoreboard drained
    int         tag;
    logic [7:0] pend;
    logic       req;
    logic       chk_id;
    logic [2:0] id;
  } dchk_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask;
  logic [7:0] pending;
  logic [7:0] pend_vec;
  logic [2:0] enc_dout;
  logic       enc_valid;
  logic       irq_ack;
  logic       ack_rand;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  irq_pending_latch_if irq_bus ();
  assign irq_bus.irq_ack = irq_ack;

  irq_pending_latch #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .pend_vec   (pend_vec),
    .enc_dout   (enc_dout),
    .enc_valid  (enc_valid),
    .irq        (irq_bus)
  );

  always #5 clk = ~clk;

  // Highest-index-wins 8-to-3 encoder standing in for the real one
  always_comb begin
    enc_valid = |pend_vec;
    enc_dout  = 3'd0;
    for (int i = 0; i < 8; i++) if (pend_vec[i]) enc_dout = 3'(i);
  end

  function automatic logic [2:0] top_bit(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Reference model state
  logic [7:0] m_pend, m_mask;
  logic       m_req;
  logic [2:0] m_id;
  int         m_gap;
  logic [7:0] hist [0:SYNC];
  logic [2:0] iss_q [$];
  dchk_t      dq [$];

  initial forever @(posedge clk) cyc++;

  // A line sampled high at edge k-SYNC after a low at k-SYNC-1 sets its pending bit at edge k
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pend = 8'h00; m_mask = 8'h00; m_req = 1'b0; m_id = 3'd0; m_gap = 0;
      for (int i = 0; i <= SYNC; i++) hist[i] = 8'h00;
      iss_q.delete();
    end else begin
      logic [7:0] set_v, pv, clr;
      set_v = hist[SYNC-1] & ~hist[SYNC];
      pv    = m_pend & ~m_mask;
      clr   = 8'h00;
      if (m_req) begin
        if (irq_ack) begin
          clr[m_id] = 1'b1;
          m_req     = 1'b0;
          m_gap     = 1;
        end
      end else if (m_gap != 0) begin
        m_gap = 0;
      end else if (pv != 8'h00) begin
        m_req = 1'b1;
        m_id  = top_bit(pv);
        iss_q.push_back(m_id);
      end
      m_pend = (m_pend & ~clr) | set_v;
      if (mask_we) m_mask = mask_wdata;
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = irq_in;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: per-cycle model comparison, issue scoreboard and timed expectations
  initial begin : monitor
    logic  prev_req;
    dchk_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("rst_irq_req",  32'(irq_bus.irq_req), 32'd0);
        chk("rst_irq_id",   32'(irq_bus.irq_id),  32'd0);
        chk("rst_pending",  32'(pending),         32'd0);
        chk("rst_pend_vec", 32'(pend_vec),        32'd0);
        chk("rst_mask",     32'(mask),            32'd0);
        prev_req = 1'b0;
      end else begin
        chk("irq_req",  32'(irq_bus.irq_req), 32'(m_req));
        chk("pending",  32'(pending),         32'(m_pend));
        chk("pend_vec", 32'(pend_vec),        32'(m_pend & ~m_mask));
        chk("mask",     32'(mask),            32'(m_mask));
        if (m_req) chk("irq_id_held", 32'(irq_bus.irq_id), 32'(m_id));
        if (irq_bus.irq_req && !prev_req) begin
          if (iss_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL issue_unexpected at cycle %0d: got id %0d, expected no issue", cyc, irq_bus.irq_id);
          end else begin
            chk("issue_id", 32'(irq_bus.irq_id), 32'(iss_q.pop_front()));
          end
        end
        prev_req = irq_bus.irq_req;
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
          e = dq.pop_front();
          if (e.kind == 1) begin
            n_chk++; n_fail++;
            $display("FAIL wait_%0d: bound expired at cycle %0d, condition not reached", e.tag, cyc);
          end else if (e.kind == 2) begin
            chk("issue_queue_empty", 32'(iss_q.size()), 32'd0);
          end else if (e.cyc < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL dir_%0d: check for cycle %0d missed at %0d", e.tag, e.cyc, cyc);
          end else begin
            chk($sformatf("dir_%0d_pending", e.tag), 32'(pending), 32'(e.pend));
            chk($sformatf("dir_%0d_irq_req", e.tag), 32'(irq_bus.irq_req), 32'(e.req));
            if (e.chk_id) chk($sformatf("dir_%0d_irq_id", e.tag), 32'(irq_bus.irq_id), 32'(e.id));
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (ack_rand) irq_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input int at, input int kind, input int tag, input logic [7:0] p,
                      input logic r, input logic ci, input logic [2:0] id);
    dchk_t e;
    e.cyc = at; e.kind = kind; e.tag = tag; e.pend = p; e.req = r; e.chk_id = ci; e.id = id;
    dq.push_back(e);
  endtask

  task automatic wait_req(input int bound, input int tag);
    int n;
    n = 0;
    while (irq_bus.irq_req !== 1'b1 && n < bound) begin tick(); n++; end
    if (irq_bus.irq_req !== 1'b1) push(cyc + 1, 1, tag, 8'h00, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic wait_pend(input logic [7:0] v, input int bound, input int tag);
    int n;
    n = 0;
    while (!(pending === v && irq_bus.irq_req === 1'b0) && n < bound) begin tick(); n++; end
    if (!(pending === v && irq_bus.irq_req === 1'b0)) push(cyc + 1, 1, tag, 8'h00, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int c;
    rst_n = 1'b0; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
    irq_ack = 1'b0; ack_rand = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single request on bit 2: pending at edge 3, issue at edge 4, no re-issue while held
    c = cyc; irq_in = 8'h04;
    push(c + 2, 0, 10, 8'h00, 1'b0, 1'b0, 3'd0);
    push(c + 3, 0, 11, 8'h04, 1'b0, 1'b0, 3'd0);
    push(c + 4, 0, 12, 8'h04, 1'b1, 1'b1, 3'd2);
    repeat (4) tick();
    irq_ack = 1'b1;
    push(c + 5, 0, 13, 8'h00, 1'b0, 1'b0, 3'd0);
    tick();
    irq_ack = 1'b0;
    push(c + 7,  0, 14, 8'h00, 1'b0, 1'b0, 3'd0);
    push(c + 11, 0, 15, 8'h00, 1'b0, 1'b0, 3'd0);
    repeat (6) tick();
    irq_in = 8'h00;
    repeat (3) tick();

    // Stray acknowledge held high in IDLE while bit 4 becomes pending
    irq_ack = 1'b1; c = cyc; irq_in = 8'h10;
    push(c + 3, 0, 20, 8'h10, 1'b0, 1'b0, 3'd0);
    push(c + 4, 0, 21, 8'h10, 1'b1, 1'b1, 3'd4);
    push(c + 5, 0, 22, 8'h00, 1'b0, 1'b0, 3'd0);
    repeat (5) tick();
    irq_ack = 1'b0; irq_in = 8'h00;
    repeat (4) tick();

    // Set/clear collision on bit 3: new edge lands on the acknowledge edge
    irq_in = 8'h08;
    wait_req(20, 30);
    irq_in = 8'h00;
    repeat (2) tick();
    c = cyc; irq_in = 8'h08;
    repeat (2) tick();
    irq_ack = 1'b1;
    push(c + 3, 0, 31, 8'h08, 1'b0, 1'b0, 3'd0);
    push(c + 5, 0, 32, 8'h08, 1'b1, 1'b1, 3'd3);
    tick();
    irq_ack = 1'b0;
    repeat (2) tick();
    irq_ack = 1'b1;
    push(c + 6, 0, 33, 8'h00, 1'b0, 1'b0, 3'd0);
    tick();
    irq_ack = 1'b0; irq_in = 8'h00;
    repeat (4) tick();

    // Priority service of bits 7 and 5 with random acknowledge
    ack_rand = 1'b1;
    irq_in = 8'hA0;
    wait_pend(8'h00, 200, 40);
    irq_in = 8'h00;
    repeat (4) tick();

    // Masked bit 7 stays pending until unmasked
    mask_we = 1'b1; mask_wdata = 8'h80;
    tick();
    mask_we = 1'b0; irq_in = 8'h82;
    wait_pend(8'h80, 200, 50);
    repeat (5) tick();
    mask_we = 1'b1; mask_wdata = 8'h00;
    tick();
    mask_we = 1'b0;
    wait_pend(8'h00, 200, 51);
    irq_in = 8'h00;
    repeat (4) tick();

    // Random traffic: line toggles, mask writes, random acknowledge
    for (int i = 0; i < 2000; i++) begin
      tick();
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) begin
        mask_we = 1'b1; mask_wdata = 8'($urandom());
      end else begin
        mask_we = 1'b0;
      end
    end
    tick();
    mask_we = 1'b1; mask_wdata = 8'h00; irq_in = 8'h00;
    tick();
    mask_we = 1'b0;
    wait_pend(8'h00, 300, 60);
    repeat (4) tick();

    // Asynchronous reset during ISSUE with the line still high at release
    ack_rand = 1'b0; irq_ack = 1'b0;
    mask_we = 1'b1; mask_wdata = 8'h40;
    tick();
    mask_we = 1'b0; irq_in = 8'h01;
    wait_req(20, 70);
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1; c = cyc;
    push(c + 2, 0, 71, 8'h00, 1'b0, 1'b0, 3'd0);
    push(c + 3, 0, 72, 8'h01, 1'b0, 1'b0, 3'd0);
    push(c + 4, 0, 73, 8'h01, 1'b1, 1'b1, 3'd0);
    repeat (5) tick();
    ack_rand = 1'b1;
    wait_pend(8'h00, 200, 74);
    irq_in = 8'h00;
    repeat (3) tick();

    push(cyc + 1, 2, 80, 8'h00, 1'b0, 1'b0, 3'd0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
